array_divider: RTL
==================

# array_divider

Sequential restoring divider: the inverse of the team's 4×4 array multiplier. It divides a 2N-bit dividend (a multiplier product) by an N-bit divisor and returns the quotient and remainder. A start/busy/done handshake drives it. It sits beside the multiplier, so a bench can run product → divide round-trips and check that the original operands come back.

## Interface
- N, default 4: divisor width. Dividend and quotient are 2N bits, remainder is N bits.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request. Accepted only in IDLE.
- dividend  input  2N  numerator, sampled on the accepting edge.
- divisor  input  N  denominator, sampled on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  2N  registered result, held until the next completion.
- remainder  output  N  registered result, held until the next completion.
- div_by_zero  output  1  set with done when divisor was 0, held like the results.

## Operation
- States are IDLE, RUN and DONE.
- Reset: state = IDLE. busy, done, div_by_zero = 0. quotient = 0, remainder = 0. Internal iteration counter and working registers are cleared.
- IDLE to RUN: start=1 with divisor≠0. Latch the divisor. Load the working dividend shift register. Clear the partial remainder (N+1 bits). Set the counter to 2N.
- IDLE to DONE on a zero divisor: start=1 with divisor=0. No iteration. Next cycle: quotient = all ones, remainder = 0, div_by_zero = 1.
- RUN, each cycle:
  - Shift {partial remainder, dividend} left by 1. The dividend MSB enters the partial remainder LSB.
  - Trial = partial remainder − divisor, computed at N+1 bits.
  - If trial is non-negative, the partial remainder becomes trial and the quotient bit is 1. Otherwise the partial remainder is kept and the quotient bit is 0.
  - The quotient bit shifts into the LSB.
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE, one cycle:
  - done=1. quotient and remainder are driven from the working registers. Remainder is the low N bits of the partial remainder, which is always < divisor.
  - div_by_zero = 0 for a normal division.
  - Return to IDLE.
- Arithmetic: unsigned only. Results must satisfy dividend = quotient × divisor + remainder with remainder < divisor.
- Boundary rules:
  - start while busy (RUN or DONE) is ignored, not queued.
  - Operand changes after acceptance have no effect.
  - start high on the same edge done is high is ignored. A new request needs start in IDLE.
  - Dividend 0 gives quotient 0, remainder 0, with the full 2N iterations.
  - Divisor 1 gives quotient = dividend.
  - Dividend < divisor gives quotient 0, remainder = dividend.
  - rst mid-RUN or in DONE aborts to IDLE with all outputs cleared. No done pulse for the aborted operation.
  - rst takes priority over start on the same edge.

## Timing
- start is accepted at edge k, so IDLE → RUN at k. RUN occupies edges k+1 … k+2N, one quotient bit per edge.
- DONE is entered at edge k+2N. done, busy and the valid results are visible in the cycle following edge k+2N. For N=4, done is seen 9 cycles after start is sampled.
- Zero divisor: done is visible in the cycle after edge k, a latency of 1.
- busy falls the cycle after done. The earliest next acceptance is the edge after done deasserts, giving a back-to-back throughput of one division per 2N+2 cycles.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then 2 ÷ 1 (N=4) → after 9 cycles done=1, quotient=2, remainder=0, div_by_zero=0. done is high for exactly one cycle.
- Round-trip with multiplier products: 15 ÷ 3 → quotient 5 r 0, 150 ÷ 10 → 15 r 0, 225 ÷ 15 → 15 r 0. Also 200 ÷ 7 → 28 r 4 and 5 ÷ 9 → 0 r 5.
- 13 ÷ 0 → done one cycle after start, quotient=8'hFF, remainder=0, div_by_zero=1. A following 8 ÷ 2 gives 4 r 0 with div_by_zero=0.
- start pulsed every cycle with changing operands during an active 100 ÷ 9 → only 11 r 1 is reported. Exactly one done per accepted request, and busy stays high throughout.
- rst asserted at cycle 4 of RUN → next cycle busy=0 and all outputs 0, no done pulse. A new 255 ÷ 15 afterwards completes with quotient 17, remainder 0.
- Exhaustive N=4 sweep of all dividend (0–255) × divisor (1–15) pairs against a reference model → quotient, remainder and latency 9 correct in every case.

Source files
------------

// File: rtl/array_divider_if.sv
// Start/busy/done handshake and operand/result bus for the restoring divider.
interface array_divider_if #(
    parameter int N = 4
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/array_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module array_divider #(
    parameter int N = 4
) (
    input logic           clk,
    input logic           rst,
    array_divider_if.slave bus
);
    localparam int CW = $clog2(2 * N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    divisor_q;
    logic [2*N-1:0]  work;
    logic [N:0]      partial;
    logic [CW-1:0]   count;

    logic [N:0]      shifted;
    logic [N:0]      trial;
    logic            q_bit;
    logic [N:0]      next_partial;
    logic [2*N-1:0]  next_work;

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        shifted      = {partial[N-1:0], work[2*N-1]};
        trial        = shifted - {1'b0, divisor_q};
        q_bit        = ~trial[N];
        next_partial = q_bit ? trial : shifted;
        next_work    = {work[2*N-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            divisor_q       <= '0;
            work            <= '0;
            partial         <= '0;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state     <= RUN;
                            divisor_q <= bus.divisor;
                            work      <= bus.dividend;
                            partial   <= '0;
                            count     <= CW'(2 * N);
                        end
                    end
                end

                RUN: begin
                    partial <= next_partial;
                    work    <= next_work;
                    count   <= count - 1'b1;
                    // Results are registered on the last iteration so they appear with done.
                    if (count == CW'(1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.quotient    <= next_work;
                        bus.remainder   <= next_partial[N-1:0];
                        bus.div_by_zero <= 1'b0;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
